branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with per-entry saturating direction counters. It generalises the fixed Branch/Jump PC muxing into dynamic next-PC prediction.
- Sits in the IF stage. The PC is looked up in the same cycle and yields the predicted taken flag and target for the next-PC mux.
- The EX stage writes back the resolved outcome. The block keeps update and mispredict statistics.

Parameters:
- ENTRIES, 16: number of entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC and target width.
- CTR_W, 2: direction counter width, at least 1.
- STAT_W, 16: width of each statistics counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  CPU run enable. While low, lookups return 0 and updates are ignored.
- flush_i  in  1  synchronous clear of all valid bits.
- pc_i  in  ADDR_W  IF-stage lookup PC.
- pred_hit_o  out  1  lookup hit (valid and tag match).
- pred_taken_o  out  1  hit and counter MSB = 1.
- pred_target_o  out  ADDR_W  stored target on hit, else 0.
- upd_valid_i  in  1  resolved-branch update strobe.
- upd_pc_i  in  ADDR_W  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual target.
- mispred_o  out  1  registered; high for one cycle after an update that mispredicted.
- stat_upd_o  out  STAT_W  count of accepted updates.
- stat_mispred_o  out  STAT_W  count of mispredicts.

Behaviour:
- Addressing:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target, ctr[CTR_W-1:0].
- Weakly-taken value WT = 2^(CTR_W-1).
- Reset (rst_i low, asynchronous):
  - all valid = 0, all ctr = 0, all targets = 0.
  - mispred_o = 0, both stats = 0.
  - Lookup outputs are therefore 0.
- Lookup: combinational from pc_i and current table state, zero latency.
  - pred_taken_o = pred_hit_o & ctr[MSB].
  - All three lookup outputs are forced to 0 while start_i is low.
- Update: accepted when upd_valid_i & start_i & !flush_i. Takes effect at the next clock edge.
- Prediction at update: computed from pre-update state.
  - Miss: predicted not-taken.
  - Hit: predicted direction = ctr MSB.
- Mispredict is either of:
  - predicted direction != upd_taken_i; or
  - predicted taken, upd_taken_i = 1, and stored target != upd_target_i.
- Hit update:
  - taken: ctr increments, saturating at 2^CTR_W-1, and target is overwritten with upd_target_i.
  - not taken: ctr decrements, saturating at 0; target is unchanged.
- Miss update:
  - taken: allocate (valid = 1, tag, target, ctr = WT), replacing any aliased entry.
  - not taken: no change.
- Statistics:
  - stat_upd_o increments by 1 per accepted update.
  - stat_mispred_o increments by 1 per mispredicting update.
  - Both saturate at all-ones and never wrap.
- mispred_o: registered flag, equal to the mispredict result of the previous cycle's accepted update, else 0.
- flush_i:
  - clears every valid bit next edge; counters, targets and stats are kept.
  - Flush and update in the same cycle: flush wins and the update is discarded, including its stats.
- Update and lookup to the same index in the same cycle: the lookup sees pre-update contents (see the optional feature below).
- Reset mid-run: immediate return to the reset state; no partial update is committed.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: an accepted update whose index and tag match pc_i in the same cycle is forwarded to the lookup outputs that cycle.
  - Forwarded values are the post-update hit, taken (new ctr MSB) and target.
  - A not-taken miss is not forwarded.
- Undefined: the lookup always reflects registered state.

Decomposition:
- Package btb_pkg holds:
  - the IDX_W calculation function;
  - the tag-width expression;
  - the counter constants CTR_MAX and CTR_WT;
  - the entry field layout.
- One sub-module is natural: btb_sat_counter, a CTR_W saturating up/down counter next-state function with a preset-to-WT input, instantiated per entry.

Test Plan:
- Reset: assert rst_i low 3 cycles, release, start_i=1, pc_i=0x40 -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0, both stats 0.
- Allocate: update pc=0x40, taken=1, target=0x100 -> next cycle, lookup 0x40 gives hit=1, taken=1, target=0x100; mispred_o pulses 1; stat_upd=1, stat_mispred=1.
- Saturation and direction flip, continuing the allocate case:
  - 2 taken updates -> ctr=3, no mispredicts.
  - 2 not-taken updates -> both mispredict, ctr=1, lookup taken=0, hit=1.
  - Totals: stat_upd=5, stat_mispred=3.
- Alias (ENTRIES=16): allocate 0x40, then lookup 0x80 -> hit=0. Taken update to 0x80 with target 0x200 -> 0x80 hits with target 0x200, and 0x40 now misses.
- Flush collision: flush_i=1 with a taken update to 0x40 in the same cycle -> next cycle all lookups miss, stats unchanged, mispred_o=0.
- Bypass: same-cycle taken update and lookup at 0x40 to an empty table -> with BTB_BYPASS_EN, hit=1 and target visible that cycle; without it, hit=0 that cycle and hit=1 the next.

Source files
------------

// File: rtl/btb_pkg.sv
// Sizing helpers and direction-counter constants shared by the branch target buffer files.
package btb_pkg;

  function automatic int btb_idx_w(input int entries);
    int w;
    w = 0;
    while ((1 << w) < entries) w++;
    return w;
  endfunction

  // PC bits [1:0] never take part in addressing, so the tag starts above the index.
  function automatic int btb_tag_w(input int addr_w, input int entries);
    return addr_w - btb_idx_w(entries) - 2;
  endfunction

  function automatic int btb_ctr_max(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

  function automatic int btb_ctr_wt(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state function of one saturating direction counter; preset loads weakly-taken.
module btb_sat_counter
  import btb_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_q,
  input  logic             inc,
  input  logic             dec,
  input  logic             preset,
  output logic [CTR_W-1:0] ctr_d
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(btb_ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(btb_ctr_wt(CTR_W));

  always_comb begin
    ctr_d = ctr_q;
    if (preset)
      ctr_d = CTR_WT;
    else if (inc && (ctr_q != CTR_MAX))
      ctr_d = ctr_q + CTR_W'(1);
    else if (dec && (ctr_q != '0))
      ctr_d = ctr_q - CTR_W'(1);
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry saturating direction counters and update statistics.
// Define BTB_BYPASS_EN to forward a same-cycle matching update to the lookup outputs.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic              mispred_o,
  output logic [STAT_W-1:0] stat_upd_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(ADDR_W, ENTRIES);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  entry_t            tbl_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_d [ENTRIES];
  logic              mispred_p1;
  logic [STAT_W-1:0] stat_upd_q;
  logic [STAT_W-1:0] stat_mis_q;

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  entry_t           lk_ent, u_ent;
  logic             lk_hit, u_hit, u_pred, u_mis, upd_acc, alloc;
  logic             unused_lsb;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign u_idx  = upd_pc_i[IDX_W+1:2];
  assign u_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign unused_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_ent = tbl_q[lk_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

  // Prediction the IF stage would have made for the resolving branch, from pre-update state.
  assign u_ent   = tbl_q[u_idx];
  assign u_hit   = u_ent.valid && (u_ent.tag == u_tag);
  assign u_pred  = u_hit && u_ent.ctr[CTR_W-1];
  assign u_mis   = (u_pred != upd_taken_i) ||
                   (u_pred && upd_taken_i && (u_ent.target != upd_target_i));
  assign upd_acc = upd_valid_i && start_i && !flush_i;
  assign alloc   = upd_acc && upd_taken_i;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd_acc && (u_idx == IDX_W'(i));
    btb_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .ctr_q  (tbl_q[i].ctr),
      .inc    (sel && u_hit && upd_taken_i),
      .dec    (sel && u_hit && !upd_taken_i),
      .preset (sel && !u_hit && upd_taken_i),
      .ctr_d  (ctr_d[i])
    );
  end

`ifdef BTB_BYPASS_EN
  logic fwd;
  assign fwd = upd_acc && (u_idx == lk_idx) && (u_tag == lk_tag) && (u_hit || upd_taken_i);
`endif

  always_comb begin
    pred_hit_o    = 1'b0;
    pred_taken_o  = 1'b0;
    pred_target_o = '0;
    if (start_i) begin
`ifdef BTB_BYPASS_EN
      if (fwd) begin
        pred_hit_o    = 1'b1;
        pred_taken_o  = ctr_d[u_idx][CTR_W-1];
        pred_target_o = upd_taken_i ? upd_target_i : u_ent.target;
      end else
`endif
      if (lk_hit) begin
        pred_hit_o    = 1'b1;
        pred_taken_o  = lk_ent.ctr[CTR_W-1];
        pred_target_o = lk_ent.target;
      end
    end
  end

  // Stage p0 -> p1: table write, mispredict flag and statistics.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      mispred_p1 <= 1'b0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i].ctr <= ctr_d[i];
      if (flush_i) begin
        for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
      end else if (alloc) begin
        tbl_q[u_idx].valid  <= 1'b1;
        tbl_q[u_idx].tag    <= u_tag;
        tbl_q[u_idx].target <= upd_target_i;
      end
      mispred_p1 <= upd_acc && u_mis;
      if (upd_acc) begin
        stat_upd_q <= sat_inc(stat_upd_q);
        if (u_mis) stat_mis_q <= sat_inc(stat_mis_q);
      end
    end
  end

  assign mispred_o      = mispred_p1;
  assign stat_upd_o     = stat_upd_q;
  assign stat_mispred_o = stat_mis_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized bench for branch_target_buffer against a behavioural BTB model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int CTR_W   = 2;
  localparam int STAT_W  = 4;
  localparam int IDX_W   = 4;
  localparam int WT      = 2;
  localparam int CMAX    = 3;
  localparam int SMAX    = 15;
`ifdef BTB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i, start_i, flush_i, upd_valid_i, upd_taken_i;
  logic [ADDR_W-1:0] pc_i, upd_pc_i, upd_target_i;
  logic              pred_hit_o, pred_taken_o, mispred_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic [STAT_W-1:0] stat_upd_o, stat_mispred_o;

  always #5 clk_i = ~clk_i;

  branch_target_buffer #(
    .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i), .pc_i(pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .mispred_o(mispred_o), .stat_upd_o(stat_upd_o),
    .stat_mispred_o(stat_mispred_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: plain integer table, counters as bounded integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  bit [31:0]   m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_mis;
  int          m_su, m_sm;
  bit          m_acc, m_hit, m_pdir, m_bad;
  int          m_i;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
      m_mis = 0; m_su = 0; m_sm = 0;
    end else begin
      m_acc = upd_valid_i && start_i && !flush_i;
      m_mis = 0;
      if (flush_i)
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      if (m_acc) begin
        m_i    = idx_of(upd_pc_i);
        m_hit  = m_valid[m_i] && (m_tag[m_i] == tag_of(upd_pc_i));
        m_pdir = m_hit && (m_ctr[m_i] >= WT);
        m_bad  = (m_pdir != upd_taken_i) || (m_pdir && upd_taken_i && (m_tgt[m_i] != upd_target_i));
        m_mis  = m_bad;
        if (m_hit) begin
          if (upd_taken_i) begin
            m_ctr[m_i] = (m_ctr[m_i] + 1 > CMAX) ? CMAX : m_ctr[m_i] + 1;
            m_tgt[m_i] = upd_target_i;
          end else begin
            m_ctr[m_i] = (m_ctr[m_i] - 1 < 0) ? 0 : m_ctr[m_i] - 1;
          end
        end else if (upd_taken_i) begin
          m_valid[m_i] = 1; m_tag[m_i] = tag_of(upd_pc_i);
          m_tgt[m_i] = upd_target_i; m_ctr[m_i] = WT;
        end
        m_su = (m_su < SMAX) ? m_su + 1 : SMAX;
        if (m_bad) m_sm = (m_sm < SMAX) ? m_sm + 1 : SMAX;
      end
    end
  end

  function automatic void exp_lookup(output bit hit, output bit taken, output bit [31:0] tgt);
    int li, ui, nc;
    bit uh;
    li = idx_of(pc_i);
    hit = m_valid[li] && (m_tag[li] == tag_of(pc_i));
    taken = hit && (m_ctr[li] >= WT);
    tgt = hit ? m_tgt[li] : 32'h0;
    if (BYP && upd_valid_i && start_i && !flush_i && (upd_pc_i[31:2] == pc_i[31:2])) begin
      ui = idx_of(upd_pc_i);
      uh = m_valid[ui] && (m_tag[ui] == tag_of(upd_pc_i));
      if (uh || upd_taken_i) begin
        if (!uh) nc = WT;
        else if (upd_taken_i) nc = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
        else nc = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
        hit = 1;
        taken = (nc >= WT);
        tgt = upd_taken_i ? upd_target_i : m_tgt[ui];
      end
    end
    if (!start_i) begin
      hit = 0; taken = 0; tgt = 0;
    end
  endfunction

  bit        chk_en = 0;
  bit        e_hit, e_taken;
  bit [31:0] e_tgt;

  always @(negedge clk_i) begin
    if (chk_en) begin
      exp_lookup(e_hit, e_taken, e_tgt);
      chk("model_hit", 32'(pred_hit_o), 32'(e_hit));
      chk("model_taken", 32'(pred_taken_o), 32'(e_taken));
      chk("model_target", pred_target_o, e_tgt);
      chk("model_mispred", 32'(mispred_o), 32'(m_mis));
      chk("model_stat_upd", 32'(stat_upd_o), 32'(m_su));
      chk("model_stat_mis", 32'(stat_mispred_o), 32'(m_sm));
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = taken; upd_target_i = tgt;
    next();
    upd_valid_i = 1'b0;
  endtask

  task automatic look(input string tag, input logic hit, input logic taken, input logic [31:0] tgt);
    chk({tag, "_hit"}, 32'(pred_hit_o), 32'(hit));
    chk({tag, "_taken"}, 32'(pred_taken_o), 32'(taken));
    chk({tag, "_target"}, pred_target_o, tgt);
  endtask

  task automatic stats(input string tag, input int su, input int sm, input logic mis);
    chk({tag, "_stat_upd"}, 32'(stat_upd_o), 32'(su));
    chk({tag, "_stat_mis"}, 32'(stat_mispred_o), 32'(sm));
    chk({tag, "_mispred"}, 32'(mispred_o), 32'(mis));
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return $urandom;
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; pc_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1; start_i = 1'b1; pc_i = 32'h40;
    chk_en = 1;
    @(negedge clk_i);
    look("reset", 0, 0, 32'h0);
    stats("reset", 0, 0, 0);

    next(); upd(32'h40, 1, 32'h100);
    @(negedge clk_i);
    look("alloc", 1, 1, 32'h100);
    stats("alloc", 1, 1, 1);

    next();
    upd(32'h40, 1, 32'h100); upd(32'h40, 1, 32'h100);
    upd(32'h40, 0, 32'h0);   upd(32'h40, 0, 32'h0);
    @(negedge clk_i);
    look("flip", 1, 0, 32'h100);
    stats("flip", 5, 3, 1);

    next(); pc_i = 32'h80;
    @(negedge clk_i);
    look("alias_pre", 0, 0, 32'h0);
    next(); upd(32'h80, 1, 32'h200);
    @(negedge clk_i);
    look("alias_new", 1, 1, 32'h200);
    stats("alias", 6, 4, 1);
    next(); pc_i = 32'h40;
    @(negedge clk_i);
    look("alias_old", 0, 0, 32'h0);

    next(); flush_i = 1'b1; upd(32'h40, 1, 32'h300); flush_i = 1'b0;
    @(negedge clk_i);
    look("flush_40", 0, 0, 32'h0);
    stats("flush", 6, 4, 0);
    next(); pc_i = 32'h80;
    @(negedge clk_i);
    look("flush_80", 0, 0, 32'h0);

    next(); pc_i = 32'h40;
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h300;
    @(negedge clk_i);
    look("bypass_same", BYP, BYP, BYP ? 32'h300 : 32'h0);
    next(); upd_valid_i = 1'b0;
    @(negedge clk_i);
    look("bypass_next", 1, 1, 32'h300);
    stats("bypass", 7, 5, 1);

    next(); start_i = 1'b0; upd(32'h40, 0, 32'h0);
    @(negedge clk_i);
    look("stopped", 0, 0, 32'h0);
    stats("stopped", 7, 5, 0);
    next(); start_i = 1'b1;
    @(negedge clk_i);
    look("restart", 1, 1, 32'h300);
    stats("restart", 7, 5, 0);

    next();
    for (int n = 0; n < 3000; n++) begin
      start_i      = ($urandom_range(0, 19) != 0);
      flush_i      = ($urandom_range(0, 29) == 0);
      upd_valid_i  = ($urandom_range(0, 9) < 6);
      upd_taken_i  = ($urandom_range(0, 9) < 6);
      upd_pc_i     = rand_pc();
      upd_target_i = 32'($urandom_range(0, 3)) << 4;
      pc_i         = ($urandom_range(0, 1) == 1) ? upd_pc_i : rand_pc();
      next();
    end

    start_i = 1'b1; flush_i = 1'b0;
    upd_valid_i = 1'b1; upd_pc_i = 32'h44; upd_taken_i = 1'b1; upd_target_i = 32'h500;
    pc_i = 32'h48;
    #3 rst_i = 1'b0;
    @(negedge clk_i);
    look("midreset", 0, 0, 32'h0);
    stats("midreset", 0, 0, 0);
    next(); rst_i = 1'b1; upd_valid_i = 1'b0; pc_i = 32'h44;
    @(negedge clk_i);
    look("after_reset", 0, 0, 32'h0);

    next();
    for (int n = 0; n < 50; n++) begin
      upd_valid_i  = ($urandom_range(0, 9) < 6);
      upd_taken_i  = ($urandom_range(0, 9) < 6);
      upd_pc_i     = rand_pc();
      upd_target_i = 32'($urandom_range(0, 3)) << 4;
      pc_i         = ($urandom_range(0, 1) == 1) ? upd_pc_i : rand_pc();
      next();
    end
    upd_valid_i = 1'b0;
    @(negedge clk_i);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
